// File: rtl/pipeline_pkg.sv
// Shared constants and types for the MIPS pipeline stages.
package pipeline_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam logic [31:0] PC_INC    = 32'd4;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  // Fetch control states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Word-addressed instruction memory: synchronous write, asynchronous read.
// Contents are not reset so a loaded program survives a pipeline reset.
module instr_mem #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  // Debug-side program load
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, instruction memory and IF/ID latch, driven by
// the debug unit (load / free-run / single-step) and stopping on HALT_WORD.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
import pipeline_pkg::*;

module fetch_stage #(
  parameter int unsigned IM_DEPTH  = 256,
  parameter int unsigned IM_ADDR_W = 8,
  parameter logic [31:0] HALT_WORD = pipeline_pkg::HALT_WORD,
  parameter logic [31:0] NOP_WORD  = pipeline_pkg::NOP_WORD
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 is_run,
  input  logic                 is_step,
  input  logic                 is_im_we,
  input  logic [IM_ADDR_W-1:0] i_im_addr,
  input  logic [WORD_W-1:0]    i_im_data,
  input  logic                 is_PC_write,
  input  logic                 is_write_IF_ID,
  input  logic                 is_flush,
  input  logic [WORD_W-1:0]    i_pc_target,
  output logic [WORD_W-1:0]    o_IF_ID_instr,
  output logic [WORD_W-1:0]    o_IF_ID_pc4,
  output logic [WORD_W-1:0]    o_pc,
  output logic                 os_halt,
  output logic                 os_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]          o_cycle_cnt,
  output logic [31:0]          o_stall_cnt,
  output logic [15:0]          o_flush_cnt
`endif
);

  fetch_state_t state_q, state_d;

  logic [WORD_W-1:0]    pc_q;
  logic [WORD_W-1:0]    ifid_instr_q;
  logic [WORD_W-1:0]    ifid_pc4_q;
  logic                 ifid_valid_q;
  logic [WORD_W-1:0]    fetch_word;
  logic [WORD_W-1:0]    pc_plus4;
  logic [IM_ADDR_W-1:0] fetch_idx;
  logic                 advance;
  logic                 mem_we;
  logic                 halt_hit;

  // Upper PC bits are dropped, so fetch wraps modulo IM_DEPTH
  assign fetch_idx = pc_q[IM_ADDR_W+1:2];
  assign pc_plus4  = pc_q + PC_INC;

  // A HALT word only takes effect when neither stall nor flush claims the cycle
  assign halt_hit = advance && is_PC_write && !is_flush && (fetch_word == HALT_WORD);

  instr_mem #(
    .DEPTH  (IM_DEPTH),
    .ADDR_W (IM_ADDR_W)
  ) u_instr_mem (
    .clk   (i_clk),
    .we    (mem_we),
    .waddr (i_im_addr),
    .wdata (i_im_data),
    .raddr (fetch_idx),
    .rdata (fetch_word)
  );

  // FSM state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // FSM next state: halt dominates, otherwise is_run selects RUN vs IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (halt_hit)    state_d = ST_HALTED;
        else if (is_run) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (halt_hit)     state_d = ST_HALTED;
        else if (!is_run) state_d = ST_IDLE;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: advance qualifier, memory write gate, halt flag
  always_comb begin
    advance = 1'b0;
    mem_we  = 1'b0;
    os_halt = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        advance = is_step | is_run;
        mem_we  = is_im_we;
      end
      ST_RUN: begin
        advance = 1'b1;
      end
      ST_HALTED: begin
        mem_we  = is_im_we;
        os_halt = 1'b1;
      end
      default: ;
    endcase
  end

  // PC and IF/ID latch: stall beats flush beats halt beats normal fetch
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pc_q         <= '0;
      ifid_instr_q <= NOP_WORD;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else if (state_q == ST_HALTED) begin
      ifid_instr_q <= NOP_WORD;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else if (advance) begin
      if (!is_PC_write) begin
        if (is_write_IF_ID) begin
          ifid_instr_q <= fetch_word;
          ifid_pc4_q   <= pc_plus4;
          ifid_valid_q <= 1'b1;
        end
      end else if (is_flush) begin
        pc_q         <= i_pc_target;
        ifid_instr_q <= NOP_WORD;
        ifid_pc4_q   <= '0;
        ifid_valid_q <= 1'b0;
      end else if (fetch_word == HALT_WORD) begin
        ifid_instr_q <= HALT_WORD;
        ifid_pc4_q   <= pc_plus4;
        ifid_valid_q <= 1'b1;
      end else begin
        pc_q         <= pc_plus4;
        ifid_instr_q <= fetch_word;
        ifid_pc4_q   <= pc_plus4;
        ifid_valid_q <= 1'b1;
      end
    end
  end

  assign o_pc          = pc_q;
  assign o_IF_ID_instr = ifid_instr_q;
  assign o_IF_ID_pc4   = ifid_pc4_q;
  assign os_valid      = ifid_valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] cycle_cnt_q;
  logic [31:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  // Saturating event counters; advance is never set in HALTED, so they freeze
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (advance) begin
      cycle_cnt_q <= sat_inc32(cycle_cnt_q);
      if (!is_PC_write) stall_cnt_q <= sat_inc32(stall_cnt_q);
      if (is_PC_write && is_flush && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign o_cycle_cnt = cycle_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`endif

endmodule
